// File: rtl/lfsr_rand_gen_if.sv
// Draw handshake between the random generator and its consumer.
// The consumer side raises req/rnd_ack; the generator returns rnd with status.
interface lfsr_rand_gen_if #(
   parameter int OUT_W = 5
);
   logic             req;
   logic             rnd_ack;
   logic [OUT_W-1:0] rnd;
   logic             rnd_valid;
   logic             busy;
   logic             timeout;

   modport master (output req, rnd_ack, input rnd, rnd_valid, busy, timeout);
   modport slave  (input req, rnd_ack, output rnd, rnd_valid, busy, timeout);
endinterface

// File: rtl/lfsr_rand_gen.sv
// Parametrised Galois LFSR with seed load, zero-seed guard and a
// rejection-sampling draw engine returning values in [0, RANGE-1].
module lfsr_rand_gen #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAPS      = 16'h002D,
   parameter logic [WIDTH-1:0] SEED      = '1,
   parameter int               OUT_W     = 5,
   parameter int               RANGE     = 26,
   parameter int               MAX_TRIES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] q,
   output logic             lockup,
   lfsr_rand_gen_if.slave   dif
);

   localparam int             CW   = $clog2(MAX_TRIES) + 1;
   localparam logic [CW-1:0]  LAST = CW'(MAX_TRIES - 1);
   // One extra bit so RANGE = 2^OUT_W is representable
   localparam logic [OUT_W:0] RNG  = (OUT_W + 1)'(RANGE);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    tries;
   logic [OUT_W-1:0] rnd_r;
   logic             vld_r;
   logic             to_r;
   logic [OUT_W-1:0] cand;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? TAPS : '0);
   endfunction

   assign cand          = q[OUT_W-1:0];
   assign dif.rnd       = rnd_r;
   assign dif.rnd_valid = vld_r;
   assign dif.timeout   = to_r;
   assign dif.busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q      <= SEED;
         state  <= IDLE;
         tries  <= '0;
         rnd_r  <= '0;
         vld_r  <= 1'b0;
         to_r   <= 1'b0;
         lockup <= 1'b0;
      end else begin
         to_r   <= 1'b0;
         lockup <= 1'b0;
         if (load) begin
            // Zero would freeze the LFSR forever, so fall back to SEED
            q      <= (seed_in == '0) ? SEED : seed_in;
            lockup <= (seed_in == '0);
            state  <= IDLE;
            tries  <= '0;
            vld_r  <= 1'b0;
         end else begin
            if (en || state == DRAW) q <= step(q);
            case (state)
               IDLE: if (dif.req) begin
                  state <= DRAW;
                  tries <= '0;
               end
               DRAW: begin
                  if ({1'b0, cand} < RNG) begin
                     rnd_r <= cand;
                     vld_r <= 1'b1;
                     state <= DONE;
                  end else if (tries == LAST) begin
                     rnd_r <= '0;
                     vld_r <= 1'b1;
                     to_r  <= 1'b1;
                     state <= DONE;
                  end else begin
                     tries <= tries + 1'b1;
                  end
               end
               DONE: if (dif.rnd_ack) begin
                  vld_r <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Scoreboard bench: a polynomial-level model plans each draw at request time,
// a monitor pops the plan when the DUT raises rnd_valid.
module tb_lfsr_rand_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, load, lockup;
   logic [15:0] seed_in, q;
   lfsr_rand_gen_if #(.OUT_W(5)) dif ();

   lfsr_rand_gen dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
      .q(q), .lockup(lockup), .dif(dif.slave)
   );

   logic       en_b, load_b, lock_b;
   logic [7:0] seed_b, q_b;
   lfsr_rand_gen_if #(.OUT_W(5)) difb ();

   lfsr_rand_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'hFF), .OUT_W(5),
                   .RANGE(1), .MAX_TRIES(1)) dutb (
      .clk(clk), .rst(rst), .en(en_b), .load(load_b), .seed_in(seed_b),
      .q(q_b), .lockup(lock_b), .dif(difb.slave)
   );

   typedef struct {int val; bit to;} exp_t;
   exp_t sbq[$];

   int vectors = 0, miscompares = 0;
   int m_q, m_st, m_rem;   // m_st: 0 idle, 1 drawing, 2 holding result
   bit m_to, m_lock, m_plan_to;

   // Multiply by x modulo the feedback polynomial
   function automatic int stp(int v, int w, int taps);
      int t = v * 2;
      if (t >= (1 << w)) t = (t - (1 << w)) ^ taps;
      return t;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Walk candidates forward from the state the draw starts on
   task automatic plan_draw();
      int v = m_q;
      exp_t e;
      m_rem = 16; e.val = 0; e.to = 1;
      for (int k = 0; k < 16; k++) begin
         if ((v % 32) < 26) begin
            m_rem = k + 1; e.val = v % 32; e.to = 0;
            break;
         end
         v = stp(v, 16, 'h2D);
      end
      m_plan_to = e.to;
      sbq.push_back(e);
   endtask

   task automatic model_edge();
      m_to = 0; m_lock = 0;
      if (load) begin
         if (m_st == 1) void'(sbq.pop_back());
         m_lock = (seed_in == 0);
         m_q    = (seed_in == 0) ? 'hFFFF : int'(seed_in);
         m_st   = 0;
      end else begin
         if (en || m_st == 1) m_q = stp(m_q, 16, 'h2D);
         case (m_st)
            0: if (dif.req) begin plan_draw(); m_st = 1; end
            1: begin
               m_rem--;
               if (m_rem == 0) begin m_st = 2; m_to = m_plan_to; end
            end
            default: if (dif.rnd_ack) m_st = 0;
         endcase
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("q", q, m_q);
      chk("busy", dif.busy, m_st != 0);
      chk("rnd_valid", dif.rnd_valid, m_st == 2);
      chk("lockup", lockup, m_lock);
      chk("timeout", dif.timeout, m_to);
   endtask

   // Monitor: one scoreboard entry per rising rnd_valid
   initial begin
      bit pv = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && dif.rnd_valid && !pv) begin
            if (sbq.size() == 0) chk("sb_unexpected", 1, 0);
            else begin
               e = sbq.pop_front();
               chk("rnd", dif.rnd, e.val);
               chk("rnd_timeout", dif.timeout, e.to);
            end
         end
         pv = dif.rnd_valid;
      end
   end

   initial begin
      logic [4:0] held;
      int start, per;
      bit zero;
      rst = 0; en = 0; load = 0; seed_in = 0; dif.req = 0; dif.rnd_ack = 0;
      en_b = 0; load_b = 0; seed_b = 0; difb.req = 0; difb.rnd_ack = 0;
      m_q = 'hFFFF; m_st = 0; m_rem = 0;
      #12;
      chk("rst_q", q, 16'hFFFF);
      chk("rst_valid", dif.rnd_valid, 0);
      chk("rst_rnd", dif.rnd, 0);
      chk("rst_busy", dif.busy, 0);
      chk("rst_lockup", lockup, 0);
      chk("rst_qb", q_b, 8'hFF);
      @(negedge clk); rst = 1;

      // First draw from reset seed: 31 rejected, 19 accepted
      dif.req = 1; cyc(); dif.req = 0;
      cyc(); chk("draw_rej_q", q, 16'hFFD3);
      cyc(); chk("draw_rnd", dif.rnd, 19); chk("draw_valid", dif.rnd_valid, 1);
      dif.rnd_ack = 1; cyc(); dif.rnd_ack = 0;
      chk("ack_valid", dif.rnd_valid, 0); chk("ack_busy", dif.busy, 0);

      // Zero seed is rejected, then plain free-run stepping
      load = 1; seed_in = 0; cyc(); load = 0;
      chk("zload_q", q, 16'hFFFF); chk("zload_lock", lockup, 1);
      cyc(); chk("zload_lock_end", lockup, 0);
      en = 1; cyc(); chk("step1", q, 16'hFFD3);
      cyc(); chk("step2", q, 16'hFF8B);
      en = 0; cyc(); chk("hold", q, 16'hFF8B);
      load = 1; seed_in = 16'h1234; cyc(); load = 0;
      chk("load_q", q, 16'h1234); chk("load_lock", lockup, 0);

      // Load aborts a draw in progress and a finished one
      dif.req = 1; cyc(); dif.req = 0;
      load = 1; seed_in = 16'hACE1; cyc(); load = 0;
      chk("abort_draw_busy", dif.busy, 0);
      dif.req = 1; cyc(); dif.req = 0;
      for (int i = 0; i < 20 && !dif.rnd_valid; i++) cyc();
      chk("reach_done", dif.rnd_valid, 1);
      load = 1; seed_in = 16'h0F0F; cyc(); load = 0;
      chk("abort_done_valid", dif.rnd_valid, 0);
      chk("abort_done_q", q, 16'h0F0F);

      // Hold result without ack while req pulses
      dif.req = 1; cyc(); dif.req = 0;
      for (int i = 0; i < 20 && !dif.rnd_valid; i++) cyc();
      held = dif.rnd;
      for (int i = 0; i < 10; i++) begin
         dif.req = 1'($urandom_range(0, 1));
         cyc();
         chk("hold_rnd", dif.rnd, held);
         chk("hold_valid", dif.rnd_valid, 1);
      end
      dif.req = 1; dif.rnd_ack = 1; cyc();
      dif.req = 0; dif.rnd_ack = 0; cyc();
      chk("req_with_ack_ignored", dif.busy, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         en          = 1'($urandom_range(0, 1));
         dif.req     = ($urandom_range(0, 3) == 0);
         dif.rnd_ack = ($urandom_range(0, 2) == 0);
         load        = ($urandom_range(0, 29) == 0);
         seed_in     = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         cyc();
      end
      en = 0; dif.req = 0; load = 0; dif.rnd_ack = 1;
      for (int i = 0; i < 20; i++) cyc();
      chk("sb_drained", sbq.size(), 0);
      dif.rnd_ack = 0;

      // 8-bit instance: forced timeout, then full-period walk
      difb.req = 1; @(posedge clk); #1; difb.req = 0;
      @(posedge clk); #1;
      chk("b_valid", difb.rnd_valid, 1);
      chk("b_rnd", difb.rnd, 0);
      chk("b_timeout", difb.timeout, 1);
      chk("b_q", q_b, stp('hFF, 8, 'h1D));
      @(posedge clk); #1;
      chk("b_timeout_pulse", difb.timeout, 0);
      start = q_b; per = 0; zero = 0;
      en_b = 1;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk); #1;
         if (q_b == 0) zero = 1;
         if (per == 0 && q_b == start) per = i;
      end
      en_b = 0;
      chk("b_period", per, 255);
      chk("b_no_zero", zero, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
